fetch_pc_ctrl: RTL and testbench

- Fetch-side consumer of the decode-stage branch/jump target (pcsrc).
- Owns the architectural fetch PC and issues one instruction-bus request at a time.
- Applies redirects from decode, squashing any wrong-path response.
- Presents fetched instructions to decode through a valid/ready buffer.

---
 rtl/fetch_pc_ctrl_pkg.sv | 22 ++
 rtl/fetch_pc_ctrl.sv | 114 +++++++++++
 tb/tb_fetch_pc_ctrl.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/fetch_pc_ctrl_pkg.sv
// Shared types and constants for the fetch PC controller.
//   fetch_state_t : fetch FSM state encoding
//   fetch_buf_t   : one-entry instruction buffer handed to decode
//   PC_STEP       : sequential fetch increment
package fetch_pc_ctrl_pkg;

  typedef enum logic [1:0] {
    StBoot,
    StReq,
    StDiscard,
    StHold
  } fetch_state_t;

  typedef struct packed {
    logic        valid;
    logic [63:0] pc;
    logic [31:0] raw;
  } fetch_buf_t;

  localparam logic [63:0] PC_STEP = 64'd4;

endpackage

// File: rtl/fetch_pc_ctrl.sv
// Fetch PC controller: owns the fetch PC, keeps one instruction-bus request
// outstanding at a time, applies decode-stage redirects (squashing wrong-path
// responses) and hands fetched words to decode through a 1-entry buffer.
//
// Ports:
//   clk, reset            rising-edge clock, async active-low reset
//   redirect_valid/pc     taken branch/jump target from decode
//   ireq_valid/addr       instruction-bus request (address held until data_ok)
//   iresp_data_ok/data    single-cycle bus response
//   instr_valid/pc/raw    buffered instruction presented to decode
//   instr_ready           decode consumes the buffered instruction
module fetch_pc_ctrl
  import fetch_pc_ctrl_pkg::*;
#(
  parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        ireq_valid,
  output logic [63:0] ireq_addr,
  input  logic        iresp_data_ok,
  input  logic [31:0] iresp_data,
  output logic        instr_valid,
  output logic [63:0] instr_pc,
  output logic [31:0] instr_raw,
  input  logic        instr_ready
);

  fetch_state_t state_q, state_d;
  logic [63:0]  fetch_pc_q, fetch_pc_d;
  logic [63:0]  pending_pc_q, pending_pc_d;
  fetch_buf_t   buf_q, buf_d;

  always_comb begin
    state_d      = state_q;
    fetch_pc_d   = fetch_pc_q;
    pending_pc_d = pending_pc_q;
    buf_d        = buf_q;

    unique case (state_q)
      StBoot: begin
        // Any response seen here is stale from before reset and is ignored.
        state_d = StReq;
      end

      StReq: begin
        if (iresp_data_ok) begin
          if (redirect_valid) begin
            // Response belongs to the wrong path: drop it, refetch at target.
            fetch_pc_d = redirect_pc;
          end else begin
            buf_d.valid = 1'b1;
            buf_d.pc    = fetch_pc_q;
            buf_d.raw   = iresp_data;
            fetch_pc_d  = fetch_pc_q + PC_STEP;
            state_d     = StHold;
          end
        end else if (redirect_valid) begin
          // The bus request cannot be withdrawn; remember the target and wait.
          pending_pc_d = redirect_pc;
          state_d      = StDiscard;
        end
      end

      StDiscard: begin
        if (redirect_valid) begin
          pending_pc_d = redirect_pc;
        end
        if (iresp_data_ok) begin
          fetch_pc_d = redirect_valid ? redirect_pc : pending_pc_q;
          state_d    = StReq;
        end
      end

      StHold: begin
        // Redirect wins over a same-cycle accept: the instruction is squashed.
        if (redirect_valid) begin
          buf_d.valid = 1'b0;
          fetch_pc_d  = redirect_pc;
          state_d     = StReq;
        end else if (instr_ready) begin
          buf_d.valid = 1'b0;
          state_d     = StReq;
        end
      end

      default: state_d = StBoot;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= StBoot;
      fetch_pc_q   <= RESET_PC;
      pending_pc_q <= 64'd0;
      buf_q        <= '0;
    end else begin
      state_q      <= state_d;
      fetch_pc_q   <= fetch_pc_d;
      pending_pc_q <= pending_pc_d;
      buf_q        <= buf_d;
    end
  end

  // Outputs come from registered state only.
  assign ireq_valid  = (state_q == StReq) || (state_q == StDiscard);
  assign ireq_addr   = fetch_pc_q;
  assign instr_valid = buf_q.valid;
  assign instr_pc    = buf_q.pc;
  assign instr_raw   = buf_q.raw;

endmodule

// File: tb/tb_fetch_pc_ctrl.sv
module tb_fetch_pc_ctrl;

  localparam logic [63:0] RstPc = 64'h0000_0000_8000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        ireq_valid;
  logic [63:0] ireq_addr;
  logic        iresp_data_ok;
  logic [31:0] iresp_data;
  logic        instr_valid;
  logic [63:0] instr_pc;
  logic [31:0] instr_raw;
  logic        instr_ready;

  int tests = 0;
  int fails = 0;

  fetch_pc_ctrl #(.RESET_PC(RstPc)) dut (
    .clk           (clk),
    .reset         (reset),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .ireq_valid    (ireq_valid),
    .ireq_addr     (ireq_addr),
    .iresp_data_ok (iresp_data_ok),
    .iresp_data    (iresp_data),
    .instr_valid   (instr_valid),
    .instr_pc      (instr_pc),
    .instr_raw     (instr_raw),
    .instr_ready   (instr_ready)
  );

  always #5 clk = ~clk;

  // Reference model: tracks the fetch stream in terms of "booting",
  // "an instruction is buffered", "the outstanding response is wrong-path".
  bit          m_boot;
  bit          m_squash;
  logic [63:0] m_next_pc;   // address the fetcher is working on / will fetch
  logic [63:0] m_target;    // where to go once a wrong-path response drains
  bit          m_buf_v;
  logic [63:0] m_buf_pc;
  logic [31:0] m_buf_raw;

  task automatic model_reset();
    m_boot    = 1'b1;
    m_squash  = 1'b0;
    m_next_pc = RstPc;
    m_target  = 64'd0;
    m_buf_v   = 1'b0;
    m_buf_pc  = 64'd0;
    m_buf_raw = 32'd0;
  endtask

  task automatic model_step(bit r, logic [63:0] rpc, bit ok, logic [31:0] d, bit rdy);
    if (m_boot) begin
      m_boot = 1'b0;
    end else if (m_buf_v) begin
      if (r) begin
        m_buf_v   = 1'b0;
        m_next_pc = rpc;
      end else if (rdy) begin
        m_buf_v = 1'b0;
      end
    end else if (m_squash) begin
      if (r) m_target = rpc;
      if (ok) begin
        m_next_pc = m_target;
        m_squash  = 1'b0;
      end
    end else begin
      if (ok && r) begin
        m_next_pc = rpc;
      end else if (ok) begin
        m_buf_v   = 1'b1;
        m_buf_pc  = m_next_pc;
        m_buf_raw = d;
        m_next_pc = m_next_pc + 64'd4;
      end else if (r) begin
        m_squash = 1'b1;
        m_target = rpc;
      end
    end
  endtask

  task automatic exp64(string tag, logic [63:0] got, logic [63:0] want);
    tests++;
    assert (got === want) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, got, want);
    end
  endtask

  task automatic check_model(string tag);
    exp64({tag, ".ireq_valid"}, {63'd0, ireq_valid}, {63'd0, !m_boot && !m_buf_v});
    exp64({tag, ".ireq_addr"}, ireq_addr, m_next_pc);
    exp64({tag, ".instr_valid"}, {63'd0, instr_valid}, {63'd0, m_buf_v});
    exp64({tag, ".instr_pc"}, instr_pc, m_buf_pc);
    exp64({tag, ".instr_raw"}, {32'd0, instr_raw}, {32'd0, m_buf_raw});
  endtask

  // One clock: check outputs, drive inputs, advance model, step past the edge.
  task automatic cyc(string tag, bit r, logic [63:0] rpc, bit ok, logic [31:0] d, bit rdy);
    check_model(tag);
    redirect_valid = r;
    redirect_pc    = rpc;
    iresp_data_ok  = ok;
    iresp_data     = d;
    instr_ready    = rdy;
    model_step(r, rpc, ok, d, rdy);
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    iresp_data_ok  = 1'b0;
    iresp_data     = '0;
    instr_ready    = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_model("reset");
    exp64("reset_addr", ireq_addr, 64'h8000_0000);
    reset = 1'b1;

    // Basic fetch, data_ok two cycles after the request.
    cyc("boot", 0, 0, 0, 0, 0);
    exp64("t1_req_valid", {63'd0, ireq_valid}, 64'd1);
    exp64("t1_req_addr", ireq_addr, 64'h8000_0000);
    cyc("t1_w", 0, 0, 0, 0, 0);
    cyc("t1_ok", 0, 0, 1, 32'h0000_0013, 0);
    exp64("t1_ivalid", {63'd0, instr_valid}, 64'd1);
    exp64("t1_ipc", instr_pc, 64'h8000_0000);
    exp64("t1_iraw", {32'd0, instr_raw}, 64'h13);
    cyc("t1_acc", 0, 0, 0, 0, 1);
    exp64("t1_next", ireq_addr, 64'h8000_0004);

    // Redirect while a request is waiting.
    cyc("t2_r", 1, 64'h8000_0100, 0, 0, 0);
    exp64("t2_hold_addr", ireq_addr, 64'h8000_0004);
    cyc("t2_w", 0, 0, 0, 0, 0);
    cyc("t2_ok", 0, 0, 1, 32'hdead_beef, 0);
    exp64("t2_dropped", {63'd0, instr_valid}, 64'd0);
    exp64("t2_next", ireq_addr, 64'h8000_0100);

    // Two more redirects in DISCARD, the last with data_ok.
    cyc("t3_r0", 1, 64'h8000_0080, 0, 0, 0);
    cyc("t3_r1", 1, 64'h8000_0100, 0, 0, 0);
    cyc("t3_r2", 1, 64'h8000_0200, 1, 32'h1111_1111, 0);
    exp64("t3_next", ireq_addr, 64'h8000_0200);
    exp64("t3_ivalid", {63'd0, instr_valid}, 64'd0);

    // Redirect and ready in the same HOLD cycle.
    cyc("t4_ok", 0, 0, 1, 32'h00a0_0093, 0);
    exp64("t4_ipc", instr_pc, 64'h8000_0200);
    cyc("t4_rr", 1, 64'h8000_0040, 0, 0, 1);
    exp64("t4_ivalid", {63'd0, instr_valid}, 64'd0);
    exp64("t4_next", ireq_addr, 64'h8000_0040);

    // PC wrap at the top of the address space.
    cyc("t5_r", 1, 64'hFFFF_FFFF_FFFF_FFFC, 1, 32'h2222_2222, 0);
    cyc("t5_ok", 0, 0, 1, 32'h3333_3333, 0);
    exp64("t5_ipc", instr_pc, 64'hFFFF_FFFF_FFFF_FFFC);
    cyc("t5_acc", 0, 0, 0, 0, 1);
    exp64("t5_wrap", ireq_addr, 64'h0);

    // Reset while DISCARD is outstanding, stale data_ok in the BOOT cycle.
    cyc("t6_r", 1, 64'h8000_1234, 0, 0, 0);
    reset = 1'b0;
    model_reset();
    #2;
    check_model("t6_async");
    exp64("t6_async_valid", {63'd0, ireq_valid}, 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    cyc("t6_stale", 0, 0, 1, 32'h4444_4444, 0);
    exp64("t6_first", ireq_addr, 64'h8000_0000);
    exp64("t6_nostale", {63'd0, instr_valid}, 64'd0);

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      logic [63:0] rpc;
      rpc = ($urandom_range(0, 7) == 0) ? 64'hFFFF_FFFF_FFFF_FFFC
                                        : {$urandom(), $urandom()};
      cyc("rand", $urandom_range(0, 5) == 0, rpc, $urandom_range(0, 2) == 0,
          $urandom(), $urandom_range(0, 1) == 1);
    end
    check_model("final");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
